// File: rtl/segment_pkg.sv
// Shared constants for the seven-segment clock capture block: segment codes,
// digit strobe encodings, FSM state type and strobe helpers.
package segment_pkg;

  // Segment codes for 0-9, bit0=a .. bit6=g
  localparam logic [6:0] SEG_CODE [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Active-low one-hot digit strobes
  localparam logic [3:0] STB_MIN_ONES = 4'b1110;
  localparam logic [3:0] STB_MIN_TENS = 4'b1101;
  localparam logic [3:0] STB_HR_ONES  = 4'b1011;
  localparam logic [3:0] STB_HR_TENS  = 4'b0111;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CAPTURE, S_HOLD, S_COMMIT
  } state_t;

  // A strobe is usable only when exactly one line is pulled low
  function automatic logic strobe_legal(input logic [3:0] d);
    return (d == STB_MIN_ONES) || (d == STB_MIN_TENS) ||
           (d == STB_HR_ONES)  || (d == STB_HR_TENS);
  endfunction

  // Slot index of a legal strobe (0 = minute ones .. 3 = hour tens)
  function automatic logic [1:0] strobe_slot(input logic [3:0] d);
    case (d)
      STB_MIN_TENS: return 2'd1;
      STB_HR_ONES:  return 2'd2;
      STB_HR_TENS:  return 2'd3;
      default:      return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] slot_strobe(input logic [1:0] s);
    return ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational seven-segment to BCD decoder; anything that is not one of
// the ten digit glyphs is reported as illegal.
module seg7_decoder
  import segment_pkg::*;
(
  input  logic [6:0] segment,
  output logic [3:0] value,
  output logic       legal
);

  // Exact match against the glyph table
  always_comb begin
    value = '0;
    legal = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (segment == SEG_CODE[i]) begin
        value = 4'(i);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/segment_capture.sv
// Captures a multiplexed 4-digit seven-segment clock display into binary
// hours/minutes. Each digit is accepted only after its strobe and segments
// have been stable for STABLE_CYCLES, and a frame commits once all four
// slots hold a decoded digit. Optional macro RANGE_CHECK_EN rejects frames
// with minutes > 59 or hours > 23.
module segment_capture
  import segment_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 24_000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [7:0] segment,
  input  logic [3:0] digit,
  output logic [6:0] minutes,
  output logic [4:0] hours,
  output logic [3:0] dp_seen,
  output logic       frame_valid,
  output logic       pattern_err,
  output logic       link_ok
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [7:0]       seg_s1, seg_s2, seg_prev;
  logic [3:0]       dig_s1, dig_s2, dig_prev;
  state_t           state;
  logic [SW-1:0]    settle_cnt;
  logic [TW-1:0]    idle_cnt;
  logic [7:0]       cap_seg;
  logic [1:0]       cap_slot;
  logic [3:0]       mask;
  logic [3:0][3:0]  val;
  logic [3:0]       dps;

  logic [3:0]       dec_val;
  logic             dec_legal;
  logic [3:0]       mask_next;
  logic [6:0]       min_calc, hr_calc;
  logic             timeout_hit;

  seg7_decoder u_dec (
    .segment (cap_seg[6:0]),
    .value   (dec_val),
    .legal   (dec_legal)
  );

  assign mask_next   = mask | (4'b0001 << cap_slot);
  assign min_calc    = 7'(val[1]) * 7'd10 + 7'(val[0]);
  assign hr_calc     = 7'(val[3]) * 7'd10 + 7'(val[2]);
  assign timeout_hit = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Two-flop synchronizer plus one more stage for change detection
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      seg_s1 <= '0;  seg_s2 <= '0;  seg_prev <= '0;
      dig_s1 <= '1;  dig_s2 <= '1;  dig_prev <= '1;
    end else begin
      seg_s1 <= segment;  seg_s2 <= seg_s1;  seg_prev <= seg_s2;
      dig_s1 <= digit;    dig_s2 <= dig_s1;  dig_prev <= dig_s2;
    end
  end

  // Capture FSM with registered outputs and link watchdog
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state       <= S_IDLE;
      settle_cnt  <= '0;
      idle_cnt    <= '0;
      cap_seg     <= '0;
      cap_slot    <= '0;
      mask        <= '0;
      val         <= '0;
      dps         <= '0;
      minutes     <= '0;
      hours       <= '0;
      dp_seen     <= '0;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
      link_ok     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
      if (idle_cnt != TW'(TIMEOUT_CYCLES)) idle_cnt <= idle_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (strobe_legal(dig_s2)) begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
          end
        end
        S_SETTLE: begin
          if (!strobe_legal(dig_s2)) begin
            state <= S_IDLE;
          end else if (seg_s2 != seg_prev || dig_s2 != dig_prev) begin
            settle_cnt <= '0;
          end else if (settle_cnt == SW'(STABLE_CYCLES - 1)) begin
            // Latch the stable sample so a strobe change next cycle is harmless
            state    <= S_CAPTURE;
            cap_seg  <= seg_s2;
            cap_slot <= strobe_slot(dig_s2);
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          idle_cnt <= '0;
          if (dec_legal) begin
            val[cap_slot] <= dec_val;
            dps[cap_slot] <= cap_seg[7];
            mask          <= mask_next;
            state         <= (mask_next == 4'b1111) ? S_COMMIT : S_HOLD;
          end else begin
            pattern_err <= 1'b1;
            mask        <= '0;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Wait for the display to move on; the same strobe is never recaptured
          if (dig_s2 != slot_strobe(cap_slot)) begin
            state      <= strobe_legal(dig_s2) ? S_SETTLE : S_IDLE;
            settle_cnt <= '0;
          end
        end
        S_COMMIT: begin
          mask  <= '0;
          state <= S_HOLD;
`ifdef RANGE_CHECK_EN
          if (min_calc > 7'd59 || hr_calc > 7'd23) begin
            pattern_err <= 1'b1;
          end else begin
            minutes     <= min_calc;
            hours       <= hr_calc[4:0];
            dp_seen     <= dps;
            frame_valid <= 1'b1;
            link_ok     <= 1'b1;
          end
`else
          minutes     <= min_calc;
          hours       <= hr_calc[4:0];
          dp_seen     <= dps;
          frame_valid <= 1'b1;
          link_ok     <= 1'b1;
`endif
        end
        default: state <= S_IDLE;
      endcase

      // Watchdog expiry drops the link and abandons any partial frame
      if (timeout_hit && state != S_CAPTURE) begin
        mask    <= '0;
        link_ok <= 1'b0;
        state   <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_segment_capture.sv
// Self-checking bench for segment_capture: directed scenarios plus randomized
// display scans checked against a slot-level behavioural model.
module tb_segment_capture;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic [7:0] segment;
  logic [3:0] digit;
  logic [6:0] minutes;
  logic [4:0] hours;
  logic [3:0] dp_seen;
  logic       frame_valid, pattern_err, link_ok;

  always #5 sys_clk = ~sys_clk;

  segment_capture #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(24_000)) dut (
    .sys_clk(sys_clk), .rst(rst), .segment(segment), .digit(digit),
    .minutes(minutes), .hours(hours), .dp_seen(dp_seen),
    .frame_valid(frame_valid), .pattern_err(pattern_err), .link_ok(link_ok)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int fv_cnt   = 0;
  int pe_cnt   = 0;

  // Pulse counters, sampled away from the active edge
  always @(negedge sys_clk) begin
    if (rst === 1'b0) begin
      if (frame_valid === 1'b1) fv_cnt++;
      if (pattern_err === 1'b1) pe_cnt++;
    end
  end

  // ---------------- behavioural model (slot level) ----------------
  int         codes [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
  logic [3:0] strobes [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int         m_val [4];
  bit         m_dp  [4];
  bit   [3:0] m_mask;
  int         m_min, m_hr, m_fv, m_pe;
  logic [3:0] m_dps;
  bit         m_link;

  function automatic int tb_decode(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (codes[i] == int'(s)) return i;
    return -1;
  endfunction

  function automatic int slot_of(input logic [3:0] d);
    for (int i = 0; i < 4; i++) if (strobes[i] == d) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mask = 0; m_min = 0; m_hr = 0; m_dps = 0; m_link = 0;
    for (int i = 0; i < 4; i++) begin m_val[i] = 0; m_dp[i] = 0; end
  endtask

  // A slot shown for >= 20 cycles is captured; <= 12 cycles never is
  task automatic drive_slot(input logic [3:0] d, input logic [7:0] s, input int n);
    int sl, k, mn, hr;
    segment = s;
    digit   = d;
    repeat (n) @(negedge sys_clk);
    sl = slot_of(d);
    if (n >= 20 && sl >= 0) begin
      k = tb_decode(s[6:0]);
      if (k < 0) begin
        m_pe++;
        m_mask = 0;
      end else begin
        m_val[sl] = k;
        m_dp[sl]  = s[7];
        m_mask[sl] = 1'b1;
        if (m_mask == 4'b1111) begin
          m_mask = 0;
          mn = m_val[1] * 10 + m_val[0];
          hr = m_val[3] * 10 + m_val[2];
`ifdef RANGE_CHECK_EN
          if (mn > 59 || hr > 23) m_pe++;
          else begin
            m_min = mn; m_hr = hr % 32; m_link = 1; m_fv++;
            for (int i = 0; i < 4; i++) m_dps[i] = m_dp[i];
          end
`else
          m_min = mn % 128; m_hr = hr % 32; m_link = 1; m_fv++;
          for (int i = 0; i < 4; i++) m_dps[i] = m_dp[i];
`endif
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    rst = 1'b1; segment = 8'h00; digit = 4'b1111;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic scan(input logic [7:0] s0, input logic [7:0] s1,
                      input logic [7:0] s2, input logic [7:0] s3);
    drive_slot(4'b1110, s0, 20);
    drive_slot(4'b1101, s1, 20);
    drive_slot(4'b1011, s2, 20);
    drive_slot(4'b0111, s3, 20);
    repeat (6) @(negedge sys_clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_slot(4'b1110, 8'h4F, 20);
    drive_slot(4'b1101, 8'h5B, 20);
    do_reset();
    n_checks++; if (minutes !== 7'd0) begin n_fail++; $display("FAIL reset_minutes got %0d want 0", minutes); end
    n_checks++; if (hours !== 5'd0) begin n_fail++; $display("FAIL reset_hours got %0d want 0", hours); end
    n_checks++; if (dp_seen !== 4'd0) begin n_fail++; $display("FAIL reset_dp got %b want 0000", dp_seen); end
    n_checks++; if (frame_valid !== 1'b0 || pattern_err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got fv=%b pe=%b want 0 0", frame_valid, pattern_err); end
    n_checks++; if (link_ok !== 1'b0) begin n_fail++; $display("FAIL reset_link got %b want 0", link_ok); end
  endtask

  task automatic test_basic_scan();
    int base;
    do_reset();
    base = fv_cnt;
    scan(8'h4F, 8'h5B, 8'h86, 8'h06);
    n_checks++; if (fv_cnt - base !== 1) begin n_fail++; $display("FAIL scan_fv_count got %0d want 1", fv_cnt - base); end
    n_checks++; if (minutes !== 7'd23) begin n_fail++; $display("FAIL scan_minutes got %0d want 23", minutes); end
    n_checks++; if (hours !== 5'd11) begin n_fail++; $display("FAIL scan_hours got %0d want 11", hours); end
    n_checks++; if (dp_seen !== 4'b0100) begin n_fail++; $display("FAIL scan_dp got %b want 0100", dp_seen); end
    n_checks++; if (link_ok !== 1'b1) begin n_fail++; $display("FAIL scan_link got %b want 1", link_ok); end
  endtask

  task automatic test_short_slot();
    int fb, pb;
    do_reset();
    fb = fv_cnt; pb = pe_cnt;
    drive_slot(4'b1110, 8'h4F, 10);
    drive_slot(4'b1101, 8'h49, 10);
    drive_slot(4'b1011, 8'h86, 10);
    drive_slot(4'b0111, 8'h06, 10);
    drive_slot(4'b1111, 8'h00, 10);
    n_checks++; if (fv_cnt - fb !== 0) begin n_fail++; $display("FAIL short_fv got %0d want 0", fv_cnt - fb); end
    n_checks++; if (pe_cnt - pb !== 0) begin n_fail++; $display("FAIL short_pe got %0d want 0", pe_cnt - pb); end
    n_checks++; if (link_ok !== 1'b0) begin n_fail++; $display("FAIL short_link got %b want 0", link_ok); end
  endtask

  task automatic test_pattern_err();
    int fb, pb;
    do_reset();
    fb = fv_cnt; pb = pe_cnt;
    scan(8'h4F, 8'h49, 8'h86, 8'h06);
    n_checks++; if (pe_cnt - pb !== 1) begin n_fail++; $display("FAIL pat_pe got %0d want 1", pe_cnt - pb); end
    n_checks++; if (fv_cnt - fb !== 0) begin n_fail++; $display("FAIL pat_no_fv got %0d want 0", fv_cnt - fb); end
    scan(8'h4F, 8'h5B, 8'h86, 8'h06);
    n_checks++; if (fv_cnt - fb !== 1) begin n_fail++; $display("FAIL pat_recover_fv got %0d want 1", fv_cnt - fb); end
    n_checks++; if (minutes !== 7'd23 || hours !== 5'd11) begin n_fail++; $display("FAIL pat_recover_time got %0d:%0d want 11:23", hours, minutes); end
  endtask

  // Runs right after a commit; display freezes on the last slot
  task automatic test_timeout();
    repeat (23000) @(negedge sys_clk);
    n_checks++; if (link_ok !== 1'b1) begin n_fail++; $display("FAIL timeout_early got link %b want 1", link_ok); end
    repeat (1100) @(negedge sys_clk);
    n_checks++; if (link_ok !== 1'b0) begin n_fail++; $display("FAIL timeout_link got %b want 0", link_ok); end
    n_checks++; if (minutes !== 7'd23 || hours !== 5'd11 || dp_seen !== 4'b0100) begin n_fail++; $display("FAIL timeout_hold got %0d:%0d dp %b want 11:23 dp 0100", hours, minutes, dp_seen); end
  endtask

  task automatic test_range();
    int fb, pb;
    do_reset();
    fb = fv_cnt; pb = pe_cnt;
    scan(8'h6D, 8'h07, 8'h6F, 8'h6F);
`ifdef RANGE_CHECK_EN
    n_checks++; if (fv_cnt - fb !== 0 || pe_cnt - pb !== 1) begin n_fail++; $display("FAIL range_pulses got fv %0d pe %0d want 0 1", fv_cnt - fb, pe_cnt - pb); end
    n_checks++; if (minutes !== 7'd0 || hours !== 5'd0 || link_ok !== 1'b0) begin n_fail++; $display("FAIL range_hold got %0d:%0d link %b want 0:0 link 0", hours, minutes, link_ok); end
`else
    n_checks++; if (fv_cnt - fb !== 1 || pe_cnt - pb !== 0) begin n_fail++; $display("FAIL range_pulses got fv %0d pe %0d want 1 0", fv_cnt - fb, pe_cnt - pb); end
    n_checks++; if (minutes !== 7'd75 || hours !== 5'd3 || link_ok !== 1'b1) begin n_fail++; $display("FAIL range_commit got %0d:%0d link %b want 3:75 link 1", hours, minutes, link_ok); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    int fb;
    do_reset();
    fb = fv_cnt;
    drive_slot(4'b1110, 8'h4F, 20);
    drive_slot(4'b1101, 8'h5B, 20);
    drive_slot(4'b1011, 8'h86, 20);
    do_reset();
    drive_slot(4'b0111, 8'h06, 20);
    repeat (6) @(negedge sys_clk);
    n_checks++; if (fv_cnt - fb !== 0) begin n_fail++; $display("FAIL midrst_no_fv got %0d want 0", fv_cnt - fb); end
    drive_slot(4'b1110, 8'h66, 20);
    drive_slot(4'b1101, 8'h06, 20);
    drive_slot(4'b1011, 8'h5B, 20);
    repeat (6) @(negedge sys_clk);
    n_checks++; if (fv_cnt - fb !== 1) begin n_fail++; $display("FAIL midrst_fresh_fv got %0d want 1", fv_cnt - fb); end
    n_checks++; if (minutes !== 7'd14 || hours !== 5'd12) begin n_fail++; $display("FAIL midrst_time got %0d:%0d want 12:14", hours, minutes); end
  endtask

  task automatic test_random();
    int prev, idx, n, v;
    logic [7:0] s;
    do_reset();
    m_fv = fv_cnt; m_pe = pe_cnt;
    prev = -1;
    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < 40; e++) begin
        do idx = $urandom_range(0, 3); while (idx == prev);
        prev = idx;
        n = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 12) : $urandom_range(20, 28);
        if ($urandom_range(0, 9) == 0) begin
          do v = $urandom_range(0, 127); while (tb_decode(7'(v)) >= 0);
          s = {1'($urandom_range(0, 1)), 7'(v)};
        end else begin
          s = {1'($urandom_range(0, 1)), 7'(codes[$urandom_range(0, 9)])};
        end
        drive_slot(strobes[idx], s, n);
      end
      repeat (6) @(negedge sys_clk);
      n_checks++; if (fv_cnt !== m_fv) begin n_fail++; $display("FAIL rand%0d_fv got %0d want %0d", r, fv_cnt, m_fv); end
      n_checks++; if (pe_cnt !== m_pe) begin n_fail++; $display("FAIL rand%0d_pe got %0d want %0d", r, pe_cnt, m_pe); end
      n_checks++; if (int'(minutes) !== m_min || int'(hours) !== m_hr) begin n_fail++; $display("FAIL rand%0d_time got %0d:%0d want %0d:%0d", r, hours, minutes, m_hr, m_min); end
      n_checks++; if (dp_seen !== m_dps || link_ok !== m_link) begin n_fail++; $display("FAIL rand%0d_dp_link got %b/%b want %b/%b", r, dp_seen, link_ok, m_dps, m_link); end
    end
  endtask

  initial begin
    rst = 1'b1; segment = 8'h00; digit = 4'b1111;
    m_fv = 0; m_pe = 0;
    model_reset();
    repeat (2) @(negedge sys_clk);
    test_reset();
    test_basic_scan();
    test_short_slot();
    test_pattern_err();
    test_timeout();
    test_range();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/segment_capture.md
SEGMENT_CAPTURE -- requirements
Module: segment_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16: consecutive identical sampled cycles before a digit is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 24_000: cycles with no capture before the link is declared lost.
REQ-003 SHALL have port sys_clk, input, 1, sole clock.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port segment, input, 8, segment lines: bit0=a..bit6=g, bit7=dp, active-high.
REQ-006 SHALL have port digit, input, 4, active-low one-hot strobe: 1110 minute ones, 1101 minute tens, 1011 hour ones, 0111 hour tens.
REQ-007 SHALL have port minutes, output, 7, binary minutes of the last committed frame.
REQ-008 SHALL have port hours, output, 5, binary hours of the last committed frame.
REQ-009 SHALL have port dp_seen, output, 4, dp bit per digit slot (index 0 = minute ones) of the last committed frame.
REQ-010 SHALL have port frame_valid, output, 1, one-cycle pulse on commit.
REQ-011 SHALL have port pattern_err, output, 1, one-cycle pulse on an undecodable segment pattern.
REQ-012 SHALL have port link_ok, output, 1, high from first commit until timeout.

Function
REQ-013 SHALL pass segment and digit through a 2-flop synchronizer; all decisions use the synchronized values (2-cycle input latency).
REQ-014 SHALL run FSM states IDLE, SETTLE, CAPTURE, HOLD, COMMIT.
REQ-015 IDLE: a strobe with exactly one zero bit -> SETTLE with the settle counter at 0; any other strobe (blank or multi-zero) stays in IDLE.
REQ-016 SETTLE: counter increments while segment and digit equal the previous cycle's values; any change clears the counter; an illegal strobe -> IDLE; counter == STABLE_CYCLES-1 -> CAPTURE.
REQ-017 CAPTURE (one cycle): decode segment[6:0] to 0-9; if legal, store the value and dp in the slot and set the slot's mask bit; if illegal, pulse pattern_err and clear the whole mask; -> HOLD.
REQ-018 HOLD: stay until digit changes; then -> SETTLE if the new strobe is legal, else IDLE; no recapture of the same strobe.
REQ-019 Recapturing an already-set slot before the mask is full SHALL overwrite that slot.
REQ-020 Mask == 1111 after CAPTURE -> COMMIT instead of HOLD; COMMIT (one cycle) loads minutes = tens*10+ones and hours = tens*10+ones; sets dp_seen; pulses frame_valid in the same cycle; sets link_ok; clears mask; -> HOLD.
REQ-021 Idle counter SHALL clear on every CAPTURE and saturate at TIMEOUT_CYCLES; reaching it clears mask, drops link_ok and forces IDLE; minutes, hours and dp_seen hold their values.
REQ-022 Arithmetic SHALL be unsigned; products are computed at 7 bits; hours is truncated to 5 bits.

Reset
REQ-023 rst SHALL set state IDLE, counters 0, mask 0, synchronizer flops to segment 00 / digit 1111, and all outputs 0.
REQ-024 rst asserted mid-frame SHALL discard the partial frame; no frame_valid pulse follows.

Configuration
REQ-025 With RANGE_CHECK_EN defined, COMMIT SHALL reject frames with minutes>59 or hours>23: pulse pattern_err, clear mask, leave minutes/hours/dp_seen/link_ok unchanged, no frame_valid.
REQ-026 Without RANGE_CHECK_EN, every fully decoded frame SHALL commit.

Structure
REQ-027 Shared package segment_pkg SHALL hold the 10 segment codes (0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F), the four strobe constants and the FSM state enum.
REQ-028 Combinational sub-module seg7_decoder SHALL map segment[6:0] to a 4-bit value plus a legal flag.

Verification
REQ-029 Scan 1110:4F, 1101:5B, 1011:86, 0111:06, 20 cycles each -> frame_valid once, hours=11, minutes=23, dp_seen=0100, link_ok=1.
REQ-030 Slot held only 10 cycles (STABLE_CYCLES=16) -> no capture, no frame_valid.
REQ-031 Pattern 0x49 on minute tens -> pattern_err pulse, mask cleared; next full clean scan commits.
REQ-032 Scan stops after a commit for 24_000 cycles -> link_ok=0; outputs keep their last values.
REQ-033 Scan showing 75:99 -> commits with RANGE_CHECK_EN undefined; pattern_err and no update with it defined.
REQ-034 rst pulse after 3 slots captured, then 1 slot -> no frame_valid until 4 fresh slots are captured.
